// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the iterative MUL/DIV sequencer: register size,
// FSM state encodings and the fixed latency the hazard unit relies on.
package alu_muldiv_seq_pkg;

  localparam int REG_SIZE       = 8;
  localparam int MULDIV_LATENCY = REG_SIZE + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Issue/result bundle between the execute stage (master) and the
// multi-cycle MUL/DIV sequencer (slave).
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] src_0;
  logic [WIDTH-1:0] src_1;
  logic             flush;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op_div, src_0, src_1, flush,
    input  busy, stall_req, done, result, div_by_zero
  );

  modport slave (
    input  start, op_div, src_0, src_1, flush,
    output busy, stall_req, done, result, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_seq_step.sv
// One iteration of the sequencer datapath: a shift-add multiply step or a
// restoring divide step. Registers not used by the selected op pass through.
module muldiv_step #(
  parameter int WIDTH = 8
) (
  input  logic               op_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [WIDTH:0]     rem,
  input  logic [WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt,
  output logic [WIDTH:0]     rem_nxt,
  output logic [WIDTH-1:0]   quo_nxt
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic             fits;

  // Trial subtraction on the shifted remainder; no borrow means divisor fits.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {2'b00, divisor};
    fits   = ~diff[WIDTH+1];
  end

  // Select the multiply or divide update, holding the unused registers.
  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    rem_nxt    = rem;
    quo_nxt    = quo;
    if (op_div) begin
      quo_nxt = {quo[WIDTH-2:0], fits};
      rem_nxt = fits ? diff[WIDTH:0] : rem_sh[WIDTH:0];
    end else begin
      acc_nxt    = mplier[0] ? (acc + mcand) : acc;
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/DIV sequencer beside the execute-stage ALU.
// Produces one result bit per cycle, stalls the pipeline front while
// iterating and pulses done for one cycle with a registered result.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter  int WIDTH = REG_SIZE,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic             clk,
  input logic             rst_n,
  alu_muldiv_seq_if.slave bus
);

  muldiv_state_e state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               op_r;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [WIDTH:0]     rem, rem_nxt;
  logic [WIDTH-1:0]   quo, quo_nxt, divisor;
  logic [WIDTH-1:0]   result_r;
  logic               dbz_r;
  logic               accept, div_zero, last_iter;

  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign div_zero  = bus.op_div && (bus.src_1 == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_div     (op_r),
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .rem        (rem),
    .quo        (quo),
    .divisor    (divisor),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt),
    .rem_nxt    (rem_nxt),
    .quo_nxt    (quo_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush always wins and a zero divisor skips RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = div_zero ? DONE : RUN;
      RUN: begin
        if (bus.flush)      state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-cycle iteration and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_r     <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      result_r <= '0;
      dbz_r    <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      op_r    <= bus.op_div;
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, bus.src_0};
      mplier  <= bus.src_1;
      rem     <= '0;
      quo     <= bus.src_0;
      divisor <= bus.src_1;
      dbz_r   <= div_zero;
      if (div_zero) result_r <= '1;
    end else if ((state == RUN) && !bus.flush) begin
      cnt    <= cnt + CNT_W'(1);
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      rem    <= rem_nxt;
      quo    <= quo_nxt;
      if (last_iter) result_r <= op_r ? quo_nxt : acc_nxt[WIDTH-1:0];
    end
  end

  assign bus.busy        = (state == RUN) || (state == DONE);
  assign bus.done        = (state == DONE);
  assign bus.stall_req   = rst_n && (accept || (state == RUN));
  assign bus.result      = result_r;
  assign bus.div_by_zero = dbz_r;

endmodule
